// File: rtl/wb_port_scheduler_pkg.sv
// Shared constants, payload type and helpers for the writeback port scheduler.
// Register ids, data width, FIFO geometry and Y86 icode values live here.
package wb_port_scheduler_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned NREG   = 15;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = PTR_W + 2;

  localparam logic [REG_W-1:0] RNONE = 4'hF;
  localparam logic [REG_W-1:0] RSP   = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // True for ids that name a real architectural register.
  function automatic logic is_arch_reg(input logic [REG_W-1:0] r);
    return (r != RNONE) && (32'(r) < NREG);
  endfunction

endpackage

// File: rtl/wb_port_scheduler_if.sv
// Writeback request, register-file write port and decode hazard query bundle.
// master = writeback/decode side, slave = scheduler.
interface wb_port_scheduler_if;
  import wb_port_scheduler_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_dste;
  logic [DATA_W-1:0] in_vale;
  logic [REG_W-1:0]  in_dstm;
  logic [DATA_W-1:0] in_valm;
  logic              wr_en;
  logic [REG_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [REG_W-1:0]  srca;
  logic [REG_W-1:0]  srcb;
  logic              hazard_a;
  logic              hazard_b;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output flush, in_valid, in_dste, in_vale, in_dstm, in_valm, srca, srcb,
    input  in_ready, wr_en, wr_addr, wr_data, hazard_a, hazard_b, occupancy
  );

  modport slave (
    input  flush, in_valid, in_dste, in_vale, in_dstm, in_valm, srca, srcb,
    output in_ready, wr_en, wr_addr, wr_data, hazard_a, hazard_b, occupancy
  );

endinterface

// File: rtl/wb_port_scheduler_fifo.sv
// In-order write FIFO: up to two pushes (slot0 then slot1) and one pop per cycle.
// Pointers carry an extra MSB so full and empty are distinguishable.
module wb_port_scheduler_fifo
  import wb_port_scheduler_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push0_i,
  input  wb_entry_t        push0_data_i,
  input  logic             push1_i,
  input  wb_entry_t        push1_data_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             empty_o,
  output logic [OCC_W-1:0] count_o
);

  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic [PTR_W-1:0] widx0, widx1;
  wb_entry_t        mem_q [DEPTH];

  assign widx0 = wptr_q[PTR_W-1:0];
  assign widx1 = widx0 + PTR_W'(1);

  always_comb begin
    wptr_d = wptr_q + (PTR_W+1)'(push0_i) + (PTR_W+1)'(push1_i);
    rptr_d = rptr_q + (PTR_W+1)'(pop_i);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which slots are live.
  always_ff @(posedge clock) begin
    if (!flush_i) begin
      if (push0_i) mem_q[widx0] <= push0_data_i;
      if (push1_i) mem_q[widx1] <= push1_data_i;
    end
  end

  assign head_o  = mem_q[rptr_q[PTR_W-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/wb_port_scheduler.sv
// Serialises dual-destination writebacks onto one register-file write port and
// tracks per-register in-flight writes so decode can detect read-after-write hazards.
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  wb_port_scheduler_if.slave bus
);

  logic             in_ready_c;
  logic             accept;
  logic             e_ok, m_ok;
  logic             push0, push1, pop;
  wb_entry_t        slot0, slot1, head;
  logic             empty;
  logic [OCC_W-1:0] occ;

  logic              wr_en_q, wr_en_d;
  logic [REG_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             hazard_a_c, hazard_b_c;

  // A request is only taken when both of its possible entries fit.
  assign in_ready_c = (occ <= OCC_W'(DEPTH - 2)) && !bus.flush;
  assign accept     = bus.in_valid && in_ready_c;

  // Compact (E,M) so the first valid destination always lands in slot0.
  assign e_ok  = is_arch_reg(bus.in_dste);
  assign m_ok  = is_arch_reg(bus.in_dstm);
  assign push0 = accept && (e_ok || m_ok);
  assign push1 = accept && e_ok && m_ok;
  assign slot0 = e_ok ? wb_entry_t'{addr: bus.in_dste, data: bus.in_vale}
                      : wb_entry_t'{addr: bus.in_dstm, data: bus.in_valm};
  assign slot1 = wb_entry_t'{addr: bus.in_dstm, data: bus.in_valm};

  assign pop = !empty && !bus.flush;

  wb_port_scheduler_fifo u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush_i      (bus.flush),
    .push0_i      (push0),
    .push0_data_i (slot0),
    .push1_i      (push1),
    .push1_data_i (slot1),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (empty),
    .count_o      (occ)
  );

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head.addr;
      wr_data_d = head.data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= RNONE;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Count stays nonzero through the cycle the entry sits on wr_*.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (bus.flush) begin
        cnt_d[r] = '0;
      end else begin
        cnt_d[r] = cnt_q[r]
                 + CNT_W'(push0 && (slot0.addr == REG_W'(r)))
                 + CNT_W'(push1 && (slot1.addr == REG_W'(r)))
                 - CNT_W'(wr_en_q && (wr_addr_q == REG_W'(r)));
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    hazard_a_c = 1'b0;
    hazard_b_c = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if ((bus.srca == REG_W'(r)) && (cnt_q[r] != '0)) hazard_a_c = 1'b1;
      if ((bus.srcb == REG_W'(r)) && (cnt_q[r] != '0)) hazard_b_c = 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.hazard_a  = hazard_a_c;
  assign bus.hazard_b  = hazard_b_c;
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Scoreboard bench for wb_port_scheduler: expected writes are queued on acceptance
// and checked in order as they appear on the register-file port.
module tb_wb_port_scheduler;
  import wb_port_scheduler_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  wb_port_scheduler_if bus();

  wb_port_scheduler dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  wb_entry_t         exp_q [$];
  int                wr_cyc [$];
  logic [DATA_W-1:0] rf [16];

  always @(posedge clock) cycle++;

  // Write-port monitor and scoreboard count bound.
  always @(negedge clock) begin
    wb_entry_t e;
    if (reset_n && bus.wr_en === 1'b1) begin
      wr_cyc.push_back(cycle);
      rf[bus.wr_addr] = bus.wr_data;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          errors++;
          $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end
      end
    end
    for (int unsigned r = 0; r < NREG; r++) begin
      checks++;
      assert (dut.cnt_q[r] <= CNT_W'(DEPTH + 1)) else begin
        errors++;
        $display("FAIL count_bound: reg %0d count=%0d, required <= %0d", r, dut.cnt_q[r], DEPTH + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [REG_W-1:0] de, input logic [DATA_W-1:0] ve,
                      input logic [REG_W-1:0] dm, input logic [DATA_W-1:0] vm,
                      output bit stalled);
    int n = 0;
    stalled = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_dste  = de;
    bus.in_vale  = ve;
    bus.in_dstm  = dm;
    bus.in_valm  = vm;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      stalled = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end else begin
      if (de != RNONE) exp_q.push_back(wb_entry_t'{addr: de, data: ve});
      if (dm != RNONE) exp_q.push_back(wb_entry_t'{addr: dm, data: vm});
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.wr_en === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_hold_wr_en: got %b, required 0", bus.wr_en); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== RNONE) begin errors++; $display("FAIL reset_wr_addr: got %h, required f", bus.wr_addr); end
    checks++; if (bus.wr_data !== 64'd0) begin errors++; $display("FAIL reset_wr_data: got %h, required 0", bus.wr_data); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d, required 0", bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_irmovq();
    bit s;
    bus.srca = 4'd3;
    bus.srcb = RNONE;
    send(4'd3, 64'h11, RNONE, 64'hDEAD, s);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL irmovq_no_bypass: wr_en=%b, required 0", bus.wr_en); end
    checks++; if (bus.hazard_a !== 1'b1) begin errors++; $display("FAIL irmovq_hazard_pending: got %b, required 1", bus.hazard_a); end
    checks++; if (bus.hazard_b !== 1'b0) begin errors++; $display("FAIL irmovq_hazard_rnone: got %b, required 0", bus.hazard_b); end
    checks++; if (bus.occupancy !== 3'd1) begin errors++; $display("FAIL irmovq_occ: got %0d, required 1", bus.occupancy); end
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd3 || bus.wr_data !== 64'h11) begin
      errors++; $display("FAIL irmovq_write: got en=%b addr=%h data=%h, required 1/3/11", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.hazard_a !== 1'b1) begin errors++; $display("FAIL irmovq_hazard_onport: got %b, required 1", bus.hazard_a); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL irmovq_occ_after: got %0d, required 0", bus.occupancy); end
    tick();
    checks++; if (bus.hazard_a !== 1'b0) begin errors++; $display("FAIL irmovq_hazard_clear: got %b, required 0", bus.hazard_a); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL irmovq_idle: wr_en=%b, required 0", bus.wr_en); end
  endtask

  task automatic test_popq();
    bit s;
    bus.srca = 4'd4;
    bus.srcb = 4'd2;
    send(4'd4, 64'h100, 4'd2, 64'hAB, s);
    checks++; if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL popq_occ: got %0d, required 2", bus.occupancy); end
    checks++; if (bus.hazard_a !== 1'b1 || bus.hazard_b !== 1'b1) begin
      errors++; $display("FAIL popq_hazards: got a=%b b=%b, required 1/1", bus.hazard_a, bus.hazard_b); end
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd4 || bus.wr_data !== 64'h100) begin
      errors++; $display("FAIL popq_first: got en=%b addr=%h data=%h, required 1/4/100", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd2 || bus.wr_data !== 64'hAB) begin
      errors++; $display("FAIL popq_second: got en=%b addr=%h data=%h, required 1/2/ab", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b1) begin
      errors++; $display("FAIL popq_hazards_mid: got a=%b b=%b, required 0/1", bus.hazard_a, bus.hazard_b); end
    tick();
    checks++; if (bus.wr_en !== 1'b0 || bus.hazard_b !== 1'b0) begin
      errors++; $display("FAIL popq_done: got en=%b hb=%b, required 0/0", bus.wr_en, bus.hazard_b); end
  endtask

  task automatic test_popq_rsp();
    bit s;
    bus.srca = RSP;
    bus.srcb = RNONE;
    send(RSP, 64'h108, RSP, 64'h55, s);
    checks++; if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL rsp_occ: got %0d, required 2", bus.occupancy); end
    tick();
    checks++; if (bus.wr_data !== 64'h108) begin errors++; $display("FAIL rsp_first: got %h, required 108", bus.wr_data); end
    tick();
    checks++; if (bus.wr_data !== 64'h55) begin errors++; $display("FAIL rsp_second: got %h, required 55", bus.wr_data); end
    checks++; if (bus.hazard_a !== 1'b1) begin errors++; $display("FAIL rsp_hazard_last: got %b, required 1", bus.hazard_a); end
    tick();
    checks++; if (bus.hazard_a !== 1'b0) begin errors++; $display("FAIL rsp_hazard_clear: got %b, required 0", bus.hazard_a); end
    checks++; if (rf[4] !== 64'h55) begin errors++; $display("FAIL rsp_final_value: r4=%h, required 55", rf[4]); end
  endtask

  task automatic test_back_pressure();
    bit s0, s1, s2;
    int n0 = wr_cyc.size();
    send(4'd1, 64'hA1, 4'd2, 64'hA2, s0);
    send(4'd3, 64'hB1, 4'd5, 64'hB2, s1);
    send(4'd6, 64'hC1, 4'd7, 64'hC2, s2);
    checks++; if (!(s0 || s1 || s2)) begin errors++; $display("FAIL bp_ready_drop: stalls=%b%b%b, required a stall", s0, s1, s2); end
    wait_drain("bp");
    checks++; if (wr_cyc.size() - n0 != 6) begin
      errors++; $display("FAIL bp_write_count: got %0d, required 6", wr_cyc.size() - n0);
    end else begin
      checks++; if (wr_cyc[n0 + 5] - wr_cyc[n0] != 5) begin
        errors++; $display("FAIL bp_one_per_cycle: span=%0d cycles, required 5", wr_cyc[n0 + 5] - wr_cyc[n0]); end
    end
  endtask

  task automatic test_flush();
    bit s;
    int n0 = wr_cyc.size();
    bus.srca = 4'd2;
    bus.srcb = 4'd5;
    send(4'd1, 64'hF1, 4'd2, 64'hF2, s);
    send(4'd3, 64'hF3, 4'd5, 64'hF4, s);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_dste  = 4'd6;
    bus.in_dstm  = RNONE;
    #1;
    checks++; if (bus.occupancy !== 3'd3) begin errors++; $display("FAIL flush_occ_before: got %0d, required 3", bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", bus.in_ready); end
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL flush_wr_en: got %b, required 0", bus.wr_en); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d, required 0", bus.occupancy); end
    checks++; if (bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b0) begin
      errors++; $display("FAIL flush_hazards: got a=%b b=%b, required 0/0", bus.hazard_a, bus.hazard_b); end
    repeat (4) tick();
    checks++; if (wr_cyc.size() - n0 != 1) begin errors++; $display("FAIL flush_write_count: got %0d, required 1", wr_cyc.size() - n0); end
  endtask

  task automatic test_reset_mid_burst();
    bit s;
    int n0;
    bus.srca = 4'd1;
    bus.srcb = 4'd6;
    send(4'd1, 64'hE1, 4'd2, 64'hE2, s);
    send(4'd5, 64'hE3, 4'd6, 64'hE4, s);
    reset_n = 1'b0;
    exp_q.delete();
    n0 = wr_cyc.size();
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en: got %b, required 0", bus.wr_en); end
    checks++; if (bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hazards: got a=%b b=%b, required 0/0", bus.hazard_a, bus.hazard_b); end
    checks++; if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL rst_mid_occ: got %0d, required 0", bus.occupancy); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) tick();
    checks++; if (wr_cyc.size() != n0) begin errors++; $display("FAIL rst_mid_no_writes: got %0d, required 0", wr_cyc.size() - n0); end
  endtask

  task automatic test_random();
    bit s;
    for (int i = 0; i < 30; i++) begin
      send(REG_W'($urandom_range(0, 15)), {$urandom, $urandom},
           REG_W'($urandom_range(0, 15)), {$urandom, $urandom}, s);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain("random");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_dste  = RNONE;
    bus.in_vale  = '0;
    bus.in_dstm  = RNONE;
    bus.in_valm  = '0;
    bus.srca     = RNONE;
    bus.srcb     = RNONE;
    test_reset();
    test_irmovq();
    test_popq();
    test_popq_rsp();
    test_back_pressure();
    test_flush();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
